// File: rtl/spi_ram_slave_p.sv
// spi_ram_slave_p: SPI-framed RAM slave; define SPI_RAM_AUTOINC_EN for address auto-increment
module spi_ram_slave_p #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, EXEC, TX, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [5:0] LAST = 6'(DATA_W-1);
`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  state_t state, nxt;
  logic [5:0] cnt;
  logic [1:0] op;
  logic [DATA_W-1:0] pay, sh, word;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic armed, ex, last, wr_ok, rd_ok;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} + (ADDR_W+1)'(1) >= DEPTH) ? '0 : a + ADDR_W'(1);
  endfunction
  assign busy  = state != IDLE;
  assign ex    = state == EXEC && !ss_n;
  assign last  = cnt == LAST;
  assign wr_ok = {1'b0, wr_addr} < DEPTH;
  assign rd_ok = {1'b0, rd_addr} < DEPTH;
  assign word  = rd_ok ? mem[rd_addr] : '0;
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // Frame sequencing; ss_n high anywhere mid-frame aborts straight to IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = armed && !ss_n ? CMD : IDLE;
      CMD:     nxt = ss_n ? IDLE : cnt[0] ? PAYLOAD : CMD;
      PAYLOAD: nxt = ss_n ? IDLE : last ? EXEC : PAYLOAD;
      EXEC:    nxt = ss_n ? IDLE : op == 2'b11 ? TX : DONE;
      TX:      nxt = ss_n ? IDLE : last ? DONE : TX;
      DONE:    nxt = ss_n ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // Shift registers, bit counter, serial output and address registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      armed   <= 1'b0;
      cnt     <= '0;
      op      <= '0;
      pay     <= '0;
      sh      <= '0;
      miso    <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      armed   <= ss_n || (armed && state != IDLE);
      cnt     <= state != nxt ? '0 : cnt + 6'd1;
      op      <= state == CMD ? {op[0], mosi} : op;
      pay     <= state == PAYLOAD ? {pay[DATA_W-2:0], mosi} : pay;
      sh      <= ex ? word << 1 : state == TX ? sh << 1 : sh;
      miso    <= ex && op == 2'b11 ? word[DATA_W-1] : state == TX && !ss_n && !last ? sh[DATA_W-1] : 1'b0;
      wr_addr <= ex && op == 2'b00 ? pay[ADDR_W-1:0] : AUTOINC && ex && op == 2'b01 ? inc(wr_addr) : wr_addr;
      rd_addr <= ex && op == 2'b10 ? pay[ADDR_W-1:0] : AUTOINC && state == TX && !ss_n && last ? inc(rd_addr) : rd_addr;
    end
  // Memory write port; contents are never reset and out-of-range writes are dropped
  always_ff @(posedge clk)
    if (ex && op == 2'b01 && wr_ok) mem[wr_addr] <= pay;
endmodule

// File: tb/tb_spi_ram_slave_p.sv
// tb_spi_ram_slave_p: directed frame vectors against 8-bit and 16-bit instances
module tb_spi_ram_slave_p;
  logic clk = 0, rst = 1;
  logic ss8 = 1, mosi8 = 0, ss16 = 1, mosi16 = 0;
  logic miso8, busy8, miso16, busy16;
  int pass = 0, total = 0;
  typedef struct {bit w; logic [1:0] op; logic [31:0] pay; logic [31:0] want;} vec_t;
  vec_t v[$];
  spi_ram_slave_p u8 (.clk(clk), .rst(rst), .ss_n(ss8), .mosi(mosi8), .miso(miso8), .busy(busy8));
  spi_ram_slave_p #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1000)) u16 (
    .clk(clk), .rst(rst), .ss_n(ss16), .mosi(mosi16), .miso(miso16), .busy(busy16));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) pass++;
    else $display("FAIL %s: got %h expected %h", n, act, want);
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drv(input bit w, input logic s, input logic m);
    if (w) begin ss16 = s; mosi16 = m; end
    else begin ss8 = s; mosi8 = m; end
  endtask
  function automatic logic so(input bit w);
    return w ? miso16 : miso8;
  endfunction
  function automatic logic bz(input bit w);
    return w ? busy16 : busy8;
  endfunction
  task automatic frame(input bit w, input logic [1:0] op, input logic [31:0] pay,
                       input logic [31:0] want, input int rst_at);
    int dw = w ? 16 : 8;
    logic [31:0] rd = 0;
    drv(w, 1, 0); tick;
    drv(w, 0, 0); tick;
    for (int i = 1; i >= 0; i--) begin drv(w, 0, op[i]); tick; end
    for (int i = dw - 1; i >= 0; i--) begin drv(w, 0, pay[i]); tick; end
    drv(w, 0, 0); tick;
    if (op == 2'b11) begin
      for (int i = 0; i < dw; i++) begin
        if (i == rst_at) begin
          #2 rst = 1;
          #1 chk("rst_miso", 32'(so(w)), 0);
          chk("rst_busy", 32'(bz(w)), 0);
          @(negedge clk) rst = 0;
          repeat (3) tick;
          chk("rearm_busy", 32'(bz(w)), 0);
          drv(w, 1, 0); tick;
          return;
        end
        rd = {rd[30:0], so(w)};
        tick;
      end
      chk("rd_data", rd, want);
    end
    chk("done_miso", 32'(so(w)), 0);
    chk("done_busy", 32'(bz(w)), 1);
    drv(w, 1, 0); tick;
    chk("idle_busy", 32'(bz(w)), 0);
  endtask
  initial begin
    bit ai;
`ifdef SPI_RAM_AUTOINC_EN
    ai = 1;
`else
    ai = 0;
`endif
    v.push_back('{0, 2'b00, 32'h00, 0});
    v.push_back('{0, 2'b01, 32'h3C, 0});
    v.push_back('{0, 2'b11, 32'h00, 32'h3C});
    v.push_back('{0, 2'b00, 32'hFF, 0});
    v.push_back('{0, 2'b01, 32'hAA, 0});
    v.push_back('{0, 2'b10, 32'hFF, 0});
    v.push_back('{0, 2'b11, 32'h00, 32'hAA});
    v.push_back('{0, 2'b00, 32'h10, 0});
    v.push_back('{0, 2'b01, 32'h11, 0});
    v.push_back('{0, 2'b01, 32'h22, 0});
    v.push_back('{0, 2'b10, 32'h10, 0});
    v.push_back('{0, 2'b11, 32'h00, ai ? 32'h11 : 32'h22});
    v.push_back('{0, 2'b11, 32'h00, 32'h22});
    v.push_back('{0, 2'b00, 32'h00, 0});
    v.push_back('{0, 2'b01, 32'h00, 0});
    v.push_back('{0, 2'b00, 32'hFF, 0});
    v.push_back('{0, 2'b01, 32'h5A, 0});
    v.push_back('{0, 2'b01, 32'hA5, 0});
    v.push_back('{0, 2'b10, 32'hFF, 0});
    v.push_back('{0, 2'b11, 32'h00, ai ? 32'h5A : 32'hA5});
    v.push_back('{0, 2'b10, 32'h00, 0});
    v.push_back('{0, 2'b11, 32'h00, ai ? 32'hA5 : 32'h00});
    v.push_back('{1, 2'b00, 32'h3E7, 0});
    v.push_back('{1, 2'b01, 32'hBEEF, 0});
    v.push_back('{1, 2'b10, 32'h3E7, 0});
    v.push_back('{1, 2'b11, 32'h0, 32'hBEEF});
    v.push_back('{1, 2'b00, 32'h3E8, 0});
    v.push_back('{1, 2'b01, 32'h1234, 0});
    v.push_back('{1, 2'b10, 32'h3E8, 0});
    v.push_back('{1, 2'b11, 32'h0, 32'h0});
    #1;
    chk("reset_miso8", 32'(miso8), 0);
    chk("reset_busy8", 32'(busy8), 0);
    chk("reset_miso16", 32'(miso16), 0);
    chk("reset_busy16", 32'(busy16), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    tick;
    foreach (v[k]) frame(v[k].w, v[k].op, v[k].pay, v[k].want, -1);
    frame(0, 2'b00, 32'h40, 0, -1);
    frame(0, 2'b01, 32'h77, 0, -1);
    frame(0, 2'b00, 32'h40, 0, -1);
    drv(0, 1, 0); tick;
    drv(0, 0, 0); tick;
    drv(0, 0, 0); tick;
    drv(0, 0, 1); tick;
    drv(0, 0, 0); tick;
    drv(0, 0, 0); tick;
    drv(0, 1, 0); tick;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_miso", 32'(miso8), 0);
    frame(0, 2'b10, 32'h40, 0, -1);
    frame(0, 2'b11, 32'h00, 32'h77, -1);
    frame(0, 2'b01, 32'h99, 0, -1);
    frame(0, 2'b10, 32'h40, 0, -1);
    frame(0, 2'b11, 32'h00, 32'h99, -1);
    frame(0, 2'b11, 32'h00, 0, 3);
    frame(0, 2'b10, 32'h40, 0, -1);
    frame(0, 2'b11, 32'h00, 32'h99, -1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
